// File: rtl/seq_chain_ctrl.sv
// seq_chain_ctrl: walks a captured launch value down a NUM_STEPS-deep register chain,
// one stage per edge, with start/abort/busy/done control and an optional one-shot auto-launch.
module seq_chain_ctrl #(
    parameter int               WIDTH      = 8,
    parameter int               NUM_STEPS  = 3,
    parameter bit               AUTO_START = 1'b1,
    parameter logic [WIDTH-1:0] LOAD_VALUE = WIDTH'(48)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       abort,
    input  logic [WIDTH-1:0]           data_in,
    output logic                       busy,
    output logic                       done,
    output logic [NUM_STEPS-1:0]       step_oh,
    output logic [NUM_STEPS*WIDTH-1:0] chain_out
);
    localparam int KW = $clog2(NUM_STEPS);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                              state_q, state_d;
    logic [KW-1:0]                       k_q, k_d;
    logic [WIDTH-1:0]                    val_q, val_d;
    logic                                auto_q, auto_d;
    logic [NUM_STEPS-1:0][WIDTH-1:0]     chain_q, chain_d, prev;
    logic [NUM_STEPS-1:0]                step;
    logic                                last;

    // Source for each stage: stage 0 takes the captured value, stage k takes stage k-1
    assign prev = {chain_q[NUM_STEPS-2:0], val_q};
    assign last = k_q == KW'(NUM_STEPS - 1);
    assign step = (state_q == RUN) ? (NUM_STEPS'(1) << k_q) : '0;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        val_d   = val_q;
        auto_d  = auto_q;
        chain_d = chain_q;
        case (state_q)
            IDLE: begin
                if (auto_q) begin
                    state_d = RUN;
                    val_d   = LOAD_VALUE;
                    auto_d  = 1'b0;
                end else if (start) begin
                    state_d = RUN;
                    val_d   = data_in;
                end
            end
            RUN: begin
                state_d = abort ? IDLE : (last ? DONE : RUN);
                k_d     = (abort || last) ? '0 : k_q + KW'(1);
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        for (int i = 0; i < NUM_STEPS; i++)
            if (step[i] && !abort) chain_d[i] = prev[i];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            val_q   <= '0;
            auto_q  <= AUTO_START;
            chain_q <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            val_q   <= val_d;
            auto_q  <= auto_d;
            chain_q <= chain_d;
        end
    end

    assign busy      = state_q != IDLE;
    assign done      = state_q == DONE;
    assign step_oh   = step;
    assign chain_out = chain_q;
endmodule

// File: tb/tb_seq_chain_ctrl.sv
// tb_seq_chain_ctrl: random and directed runs; expected end-of-run results are queued at launch
// and popped by a monitor whenever a run ends (done pulse or busy dropping without done).
module tb_seq_chain_ctrl;
    localparam int           W  = 8;
    localparam int           N  = 3;
    localparam logic [W-1:0] LV = 8'd48;

    logic           clk = 1'b0, rst = 1'b0, start = 1'b0, abort = 1'b0;
    logic [W-1:0]   data_in = '0;
    logic           busy, done;
    logic [N-1:0]   step_oh;
    logic [N*W-1:0] chain_out;

    seq_chain_ctrl #(.WIDTH(W), .NUM_STEPS(N), .AUTO_START(1'b1), .LOAD_VALUE(LV)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .data_in(data_in),
        .busy(busy), .done(done), .step_oh(step_oh), .chain_out(chain_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic           compl;
        logic [N*W-1:0] chain;
        int             len;
    } exp_t;

    exp_t         sbq[$];
    int           errors = 0, checks = 0;
    logic [W-1:0] mchain [N];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N*W-1:0] pack_model();
        logic [N*W-1:0] r;
        for (int i = 0; i < N; i++) r[i*W +: W] = mchain[i];
        return r;
    endfunction

    // a == 0: full run; a > 0: aborted on edge E(a), so a-1 stages got loaded
    task automatic expect_run(input logic [W-1:0] v, input int a);
        exp_t e;
        int   loaded;
        loaded = (a == 0) ? N : a - 1;
        for (int i = 0; i < loaded; i++) mchain[i] = v;
        e.compl = (a == 0);
        e.chain = pack_model();
        e.len   = (a == 0) ? N + 1 : a;
        sbq.push_back(e);
    endtask

    int   cnt = 0;
    logic pb = 1'b0, pd = 1'b0;
    logic [N-1:0] es;
    exp_t me;
    always @(negedge clk) begin
        if (busy) begin
            es = done ? '0 : (N'(1) << cnt);
            chk("step_oh", 64'(step_oh), 64'(es));
            cnt++;
        end
        if (done || (pb && !busy && !pd)) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL run_end: run ended with done=%0b but no run was expected", done);
            end else begin
                me = sbq.pop_front();
                chk("run_completed", 64'(done), 64'(me.compl));
                chk("chain_at_end", 64'(chain_out), 64'(me.chain));
                chk("busy_cycles", 64'(cnt), 64'(me.len));
            end
            cnt = 0;
        end
        pb = busy;
        pd = done;
    end

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 4*N + 8) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL %s: busy got 1 expected 0 after %0d cycles", name, n);
        end
    endtask

    task automatic run(input logic [W-1:0] v, input int a, input bit hold);
        expect_run(v, a);
        start   = 1'b1;
        data_in = v;
        abort   = 1'($urandom_range(0, 1));
        @(negedge clk);
        abort   = 1'b0;
        start   = hold;
        data_in = W'($urandom);
        if (a > 0) begin
            repeat (a - 1) begin
                @(negedge clk);
                data_in = W'($urandom);
            end
            abort = 1'b1;
            start = 1'b0;
            @(negedge clk);
            abort = 1'b0;
        end else begin
            int n = 0;
            while (!done && n < N + 4) begin
                @(negedge clk);
                data_in = W'($urandom);
                n++;
            end
            start = 1'b0;
        end
        wait_idle("run_idle");
    endtask

    task automatic hold_test();
        int n = 0;
        expect_run(8'h5A, 0);
        expect_run(8'h11, 0);
        start   = 1'b1;
        data_in = 8'h5A;
        repeat (3) @(negedge clk);
        data_in = 8'h11;
        while (!done && n < N + 4) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("hold_gap_idle", 64'(busy), 64'(0));
        @(negedge clk);
        chk("hold_relaunch", 64'(busy), 64'(1));
        start = 1'b0;
        wait_idle("hold_idle");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time %0t reached limit 200000 without finishing", $time);
        $fatal(1);
    end

    initial begin
        exp_t re;
        for (int i = 0; i < N; i++) mchain[i] = '0;
        #2;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_step_oh", 64'(step_oh), 64'(0));
        chk("rst_chain", 64'(chain_out), 64'(0));
        expect_run(LV, 0);
        #8 rst = 1'b1;
        #10 chk("t20_chain", 64'(chain_out), 64'(0));
        #10 chk("t30_a", 64'(chain_out[0 +: W]), 64'(LV));
        #10 chk("t40_b", 64'(chain_out[W +: W]), 64'(LV));
        #10 begin
            chk("t50_chain", 64'(chain_out), 64'({N{LV}}));
            chk("t50_done", 64'(done), 64'(1));
        end
        #10 chk("t60_busy", 64'(busy), 64'(0));
        @(negedge clk);
        run(8'hA5, 0, 1'b0);
        hold_test();
        run(8'h77, 0, 1'b0);
        run(8'h3C, 2, 1'b0);
        for (int r = 0; r < 40; r++) begin
            int a;
            repeat ($urandom_range(0, 3)) begin
                abort = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
            abort = 1'b0;
            a = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, N)) : 0;
            run(W'($urandom), a, 1'($urandom_range(0, 1)));
        end
        re.compl = 1'b0;
        re.chain = '0;
        re.len   = 1;
        sbq.push_back(re);
        for (int i = 0; i < N; i++) mchain[i] = '0;
        expect_run(LV, 0);
        start   = 1'b1;
        data_in = 8'hC3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        #1 begin
            chk("midrst_busy", 64'(busy), 64'(0));
            chk("midrst_done", 64'(done), 64'(0));
            chk("midrst_step_oh", 64'(step_oh), 64'(0));
            chk("midrst_chain", 64'(chain_out), 64'(0));
        end
        @(posedge clk);
        #3 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("auto_relaunch", 64'(busy), 64'(1));
        wait_idle("auto_idle");
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(sbq.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
